// File: rtl/irq_ctrl.sv
// Interrupt aggregator: sync + edge/level capture + mask -> registered HWInt vector for CP0.
// Latency: irq_in sampled at E1 shows on HWInt after E2; register reads are combinational.
// Backpressure: none; a register write never stalls capture. Optional macro IRQ_MISS_CNT_EN adds a missed-edge counter.
module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:2]      Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] irq_in,
    output logic [N_SRC-1:0] HWInt,
    output logic             IRQ
);

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_MODE = 2'd1;
    localparam logic [1:0] A_PEND = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] pend_edge_q, pend_edge_d;
    logic [N_SRC-1:0] irq_s_q, irq_d_q;
    logic [N_SRC-1:0] hwint_q, hwint_d;
    logic [N_SRC-1:0] edge_w;
    logic [N_SRC-1:0] pend_eff;
    logic [N_SRC-1:0] w1c;
    logic [2:0]       lowest_idx;
    logic [7:0]       miss_cnt;
    logic             wr_mask, wr_mode, wr_pend;
    logic             unused_bits;

    assign wr_mask = WE && (Addr[3:2] == A_MASK);
    assign wr_mode = WE && (Addr[3:2] == A_MODE);
    assign wr_pend = WE && (Addr[3:2] == A_PEND);

    // Rising edge of the synchronised line and the effective pending vector seen by software and HWInt
    always_comb begin
        edge_w   = irq_s_q & ~irq_d_q;
        pend_eff = (mode_q & (pend_edge_q | edge_w)) | (~mode_q & irq_s_q);
    end

    // Next-state for config and edge-pending; a new edge beats a W1C, and leaving edge mode drops the latch
    always_comb begin
        mask_d      = wr_mask ? Din[N_SRC-1:0] : mask_q;
        mode_d      = wr_mode ? Din[N_SRC-1:0] : mode_q;
        w1c         = wr_pend ? Din[N_SRC-1:0] : '0;
        pend_edge_d = ((pend_edge_q & ~w1c) | (edge_w & mode_q)) & mode_d;
        hwint_d     = pend_eff & mask_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_q      <= '0;
            mode_q      <= '0;
            pend_edge_q <= '0;
            irq_s_q     <= '0;
            irq_d_q     <= '0;
            hwint_q     <= '0;
        end else begin
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            pend_edge_q <= pend_edge_d;
            irq_s_q     <= irq_in;
            irq_d_q     <= irq_s_q;
            hwint_q     <= hwint_d;
        end
    end

`ifdef IRQ_MISS_CNT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       miss;
    logic       wr_stat;

    assign wr_stat = WE && (Addr[3:2] == A_STAT);
    // Any edge arriving on an already-latched edge source counts once per cycle
    assign miss    = |(edge_w & mode_q & pend_edge_q);

    // Saturating missed-edge counter; a STAT write clears and beats a same-cycle increment
    always_comb begin
        cnt_d = cnt_q;
        if (wr_stat) begin
            cnt_d = 8'h00;
        end else if (miss && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'h01;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign miss_cnt = cnt_q;
`else
    assign miss_cnt = 8'h00;
`endif

    // Index of the lowest set HWInt bit, 0 when none
    always_comb begin
        lowest_idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (hwint_q[i]) begin
                lowest_idx = 3'(i);
            end
        end
    end

    // Combinational read mux over the four word registers
    always_comb begin
        Dout = 32'h0;
        case (Addr[3:2])
            A_MASK: Dout[N_SRC-1:0] = mask_q;
            A_MODE: Dout[N_SRC-1:0] = mode_q;
            A_PEND: Dout[N_SRC-1:0] = pend_eff;
            default: begin
                Dout[31]   = |hwint_q;
                Dout[15:8] = miss_cnt;
                Dout[2:0]  = lowest_idx;
            end
        endcase
    end

    assign HWInt = hwint_q;
    assign IRQ   = |hwint_q;

    assign unused_bits = ^{Addr[31:4], Din[31:N_SRC]};

endmodule
